alu_arbiter: RTL
================

# alu_arbiter

Round-robin arbiter that shares the single 32-bit combinational ALU between `N_REQ` requesters, for example the execute stage and the branch/address unit. Each requester has its own valid/ready request channel. A winner's operands and code go to the ALU, and the result is captured in a one-entry output register with backpressure. It also supports per-requester grant locking for back-to-back dependent operations, flags illegal ALU codes, and counts completed operations.

## Interface
Parameters:
- `N_REQ`, default 2: number of requesters, range 2..4.
- `CNT_W`, default 16: width of the completed-operation counter.

Ports:
- `CLK`, in, 1: single clock, rising edge.
- `RESET_N`, in, 1: reset, synchronous and active-low.
- `REQ_VALID`, in, `N_REQ`: request valid, one bit per requester.
- `REQ_READY`, out, `N_REQ`: request accepted this cycle, one bit per requester.
- `REQ_X`, in, `N_REQ`x32: X operand per requester.
- `REQ_Y`, in, `N_REQ`x32: Y operand per requester.
- `REQ_CONTROL`, in, `N_REQ`x4: ALU code per requester.
- `REQ_LOCK`, in, `N_REQ`: when set on an accepted request, that requester keeps top priority for the next grant.
- `RSP_VALID`, out, 1: response register holds a result.
- `RSP_READY`, in, 1: consumer takes the response.
- `RSP_ID`, out, `$clog2(N_REQ)`: index of the requester that owns the response.
- `RSP_RESULT`, out, 32: ALU result.
- `RSP_FLAG`, out, 1: ALU flag, which is 1 when the result is non-zero.
- `RSP_ILLEGAL`, out, 1: the request's CONTROL was not a legal code.
- `OPS_COUNT`, out, `CNT_W`: count of completed responses, saturating.

## Operation
- Legal codes: 0000 ADD, 0111 SUB, 0100 LT, 1101 GT-test, 0010 AND, 0001 OR, 1001 XOR, 0110 PASS-Y, 1000 SLL, 1010 SRL, 1110 SRA, 1011 GE-test, 1111 EQ, 0011 NE-test.
- 0101 and 1100 are illegal. For an illegal code the ALU yields 0, the response is still returned with `RSP_ILLEGAL`=1 and `RSP_FLAG`=0.
- Operands and CONTROL pass to the ALU unmodified, with no masking of shift amounts.
- Free slot: `slot_free = !RSP_VALID || RSP_READY`.
- Priority pointer `PTR`: the winner is the first i with `REQ_VALID[i]`, scanning from `PTR` upward modulo `N_REQ`.
- Grant: `REQ_READY[i]` = (i is the winner) && `slot_free`. At most one bit is set, and it is combinational from `REQ_VALID`, `PTR`, `RSP_VALID` and `RSP_READY`.
- On accept of requester i:
  - The response register loads the ALU output, the flag, the illegal bit and ID=i.
  - `RSP_VALID` is 1 next cycle.
  - `PTR` becomes i if `REQ_LOCK[i]`, else (i+1) mod `N_REQ`.
- A lock gives priority only, not exclusivity. If the locked requester drops valid, others are granted normally and `PTR` advances past the winner.
- Response held: if `RSP_VALID` && !`RSP_READY`, all response outputs stay stable and `REQ_READY` is all zero.
- Simultaneous consume and accept in one cycle: the new result replaces the old one, `RSP_VALID` stays 1, and there is no bubble.
- Consume with no accept: `RSP_VALID` goes to 0 next cycle.
- `OPS_COUNT` increments on each `RSP_VALID && RSP_READY`. It saturates at 2^`CNT_W`-1 and does not wrap.
- Reset (`RESET_N`=0 at a rising edge):
  - `RSP_VALID`=0, `RSP_ID`=0, `RSP_RESULT`=0, `RSP_FLAG`=0, `RSP_ILLEGAL`=0, `OPS_COUNT`=0, `PTR`=0.
  - `REQ_READY` is forced to all zero while `RESET_N`=0.
  - A pending response is dropped, not counted.

## Timing
- Latency: accept at edge t gives `RSP_VALID` in the cycle after t.
- Throughput: one operation per cycle while `RSP_READY`=1.
- Requester rule: holds X, Y, CONTROL and LOCK stable while `REQ_VALID`=1 and `REQ_READY`=0. It may not drop valid before acceptance.
- Consumer rule: `RSP_READY` may toggle freely. The data is sampled only when `RSP_VALID`=1.
- The ALU path is purely combinational from the winner mux to the response register, in a single cycle.

## Structure
- Shared package `alu_pkg`:
  - 4-bit enum `alu_op_t` with the 14 legal codes.
  - Function `is_legal_op`.
  - Constant `ALU_W`=32.
- Sub-module `rr_pick`: combinational round-robin winner from valid bits and `PTR`, outputting a one-hot grant and the winner index.
- The ALU is instantiated once, fed by the winner mux.

## Test plan
- After reset, req0 sends ADD with X=5, Y=7. Required: `REQ_READY[0]`=1 in the same cycle; next cycle `RSP_VALID`=1, `RSP_RESULT`=12, `RSP_ID`=0, `RSP_FLAG`=1, `RSP_ILLEGAL`=0.
- req0 and req1 both hold valid with `RSP_READY`=1. Required: grants alternate 0,1,0,1 with one response per cycle; after 4 consumed responses `OPS_COUNT`=4.
- Hold `RSP_READY`=0 for 3 cycles with both valid. Required: the response stays frozen and `REQ_READY`=00; on release, the next grant goes to the requester after the held `RSP_ID`.
- req0 sends SUB with X=9, Y=9 and `REQ_LOCK[0]`=1, while req1 is valid. Required: `RSP_RESULT`=0 and `RSP_FLAG`=0; the next grant goes to req0 again if it is valid, otherwise to req1.
- req1 sends CONTROL=0101. Required: `RSP_RESULT`=0, `RSP_ILLEGAL`=1, `RSP_FLAG`=0.
- Assert `RESET_N`=0 while `RSP_VALID`=1 and `OPS_COUNT`=5. Required: next cycle `RSP_VALID`=0, `OPS_COUNT`=0, and `PTR` restarts at req0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, legality test and datapath width.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package alu_pkg;

  localparam int ALU_W = 32;

  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_AND   = 4'b0010,
    OP_NE    = 4'b0011,
    OP_LT    = 4'b0100,
    OP_PASSY = 4'b0110,
    OP_SUB   = 4'b0111,
    OP_SLL   = 4'b1000,
    OP_XOR   = 4'b1001,
    OP_SRL   = 4'b1010,
    OP_GE    = 4'b1011,
    OP_GT    = 4'b1101,
    OP_SRA   = 4'b1110,
    OP_EQ    = 4'b1111
  } alu_op_t;

  // 0101 and 1100 are the only unassigned codes.
  function automatic logic is_legal_op(input logic [3:0] code);
    return (code != 4'b0101) && (code != 4'b1100);
  endfunction

endpackage

// File: rtl/alu.sv
// Shared 32-bit combinational ALU; compare ops are signed and return 0/1.
// Latency: purely combinational.
// Backpressure: none, the caller registers the result.
module alu
  import alu_pkg::*;
(
  input  logic [3:0]       op,
  input  logic [ALU_W-1:0] x,
  input  logic [ALU_W-1:0] y,
  output logic [ALU_W-1:0] result,
  output logic             flag,
  output logic             illegal
);

  // Operation decode; shift amounts use the full Y value, so Y >= 32 shifts everything out.
  always_comb begin
    result  = '0;
    illegal = !is_legal_op(op);
    case (op)
      OP_ADD:   result = x + y;
      OP_SUB:   result = x - y;
      OP_LT:    result = ALU_W'($signed(x) <  $signed(y));
      OP_GT:    result = ALU_W'($signed(x) >  $signed(y));
      OP_GE:    result = ALU_W'($signed(x) >= $signed(y));
      OP_EQ:    result = ALU_W'(x == y);
      OP_NE:    result = ALU_W'(x != y);
      OP_AND:   result = x & y;
      OP_OR:    result = x | y;
      OP_XOR:   result = x ^ y;
      OP_PASSY: result = y;
      OP_SLL:   result = x << y;
      OP_SRL:   result = x >> y;
      OP_SRA:   result = ALU_W'($signed(x) >>> y);
      default:  result = '0;
    endcase
    flag = |result;
  end

endmodule

// File: rtl/rr_pick.sv
// Round-robin winner select: first valid bit at or above ptr, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none, grant qualification is done by the caller.
module rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0]         vld,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  int j;

  // Scan from the farthest candidate back to ptr so the closest valid one wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    j   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (vld[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between N_REQ requesters, result in a 1-entry register.
// Latency: accept at edge t, response valid in the following cycle.
// Backpressure: grants only when the response slot is empty or being consumed.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int CNT_W = 16
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic [N_REQ-1:0]         REQ_VALID,
  output logic [N_REQ-1:0]         REQ_READY,
  input  logic [N_REQ*ALU_W-1:0]   REQ_X,
  input  logic [N_REQ*ALU_W-1:0]   REQ_Y,
  input  logic [N_REQ*4-1:0]       REQ_CONTROL,
  input  logic [N_REQ-1:0]         REQ_LOCK,
  output logic                     RSP_VALID,
  input  logic                     RSP_READY,
  output logic [$clog2(N_REQ)-1:0] RSP_ID,
  output logic [ALU_W-1:0]         RSP_RESULT,
  output logic                     RSP_FLAG,
  output logic                     RSP_ILLEGAL,
  output logic [CNT_W-1:0]         OPS_COUNT
);

  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  win_idx;
  logic             slot_free;
  logic             accept;
  logic [ALU_W-1:0] alu_x, alu_y, alu_res;
  logic [3:0]       alu_op;
  logic             alu_flag, alu_ill;

  logic             rsp_vld_q, rsp_vld_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [ALU_W-1:0] rsp_res_q, rsp_res_d;
  logic             rsp_flag_q, rsp_flag_d;
  logic             rsp_ill_q, rsp_ill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;

  rr_pick #(.N(N_REQ)) u_pick (
    .vld (REQ_VALID),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (win_idx)
  );

  // Grant the winner only when the response slot can take a new result and not in reset.
  always_comb begin
    slot_free = !rsp_vld_q || RSP_READY;
    REQ_READY = (RESET_N && slot_free) ? gnt : '0;
    accept    = |REQ_READY;
  end

  // Winner mux feeding the single ALU.
  always_comb begin
    alu_x  = REQ_X[win_idx*ALU_W +: ALU_W];
    alu_y  = REQ_Y[win_idx*ALU_W +: ALU_W];
    alu_op = REQ_CONTROL[win_idx*4 +: 4];
  end

  alu u_alu (
    .op      (alu_op),
    .x       (alu_x),
    .y       (alu_y),
    .result  (alu_res),
    .flag    (alu_flag),
    .illegal (alu_ill)
  );

  // Response register, pointer and counter next-state; an accept overwrites a consumed entry.
  always_comb begin
    rsp_vld_d  = rsp_vld_q;
    rsp_id_d   = rsp_id_q;
    rsp_res_d  = rsp_res_q;
    rsp_flag_d = rsp_flag_q;
    rsp_ill_d  = rsp_ill_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    if (rsp_vld_q && RSP_READY && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (accept) begin
      rsp_vld_d  = 1'b1;
      rsp_id_d   = win_idx;
      rsp_res_d  = alu_res;
      rsp_flag_d = alu_flag;
      rsp_ill_d  = alu_ill;
      ptr_d      = REQ_LOCK[win_idx] ? win_idx : ID_W'((int'(win_idx) + 1) % N_REQ);
    end else if (RSP_READY) begin
      rsp_vld_d  = 1'b0;
    end
  end

  // State registers with synchronous active-low reset; a pending response is dropped.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      rsp_vld_q  <= 1'b0;
      rsp_id_q   <= '0;
      rsp_res_q  <= '0;
      rsp_flag_q <= 1'b0;
      rsp_ill_q  <= 1'b0;
      cnt_q      <= '0;
      ptr_q      <= '0;
    end else begin
      rsp_vld_q  <= rsp_vld_d;
      rsp_id_q   <= rsp_id_d;
      rsp_res_q  <= rsp_res_d;
      rsp_flag_q <= rsp_flag_d;
      rsp_ill_q  <= rsp_ill_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
    end
  end

  assign RSP_VALID   = rsp_vld_q;
  assign RSP_ID      = rsp_id_q;
  assign RSP_RESULT  = rsp_res_q;
  assign RSP_FLAG    = rsp_flag_q;
  assign RSP_ILLEGAL = rsp_ill_q;
  assign OPS_COUNT   = cnt_q;

endmodule
